ad9361_tx_framer: RTL and testbench

//  Transmit-side counterpart of the AD9361 LVDS RX stream path. Takes parallel I/Q sample pairs from the

---
 rtl/ad9361_tx_framer_pkg.sv | 27 ++
 rtl/ad9361_tx_framer_if.sv | 24 ++
 rtl/ad9361_tx_framer_word_mux.sv | 29 ++
 rtl/ad9361_tx_framer.sv | 141 ++++++++++++++
 tb/tb_ad9361_tx_framer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad9361_tx_framer_pkg.sv
// Shared types and constants for the AD9361 TX framer: sample widths, frame
// lengths, the I/Q sample-set struct and the framer state encoding.
package ad9361_pkg;

  localparam int SAMPLE_W     = 12;
  localparam int WORD_W       = 6;
  localparam int FRAME_LEN_1T = 4;
  localparam int FRAME_LEN_2T = 8;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i0;
    logic [SAMPLE_W-1:0] q0;
    logic [SAMPLE_W-1:0] i1;
    logic [SAMPLE_W-1:0] q1;
  } iq_set_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index of the final half-word of a frame for the given framing mode.
  function automatic logic [2:0] last_phase(input logic two_t);
    return two_t ? 3'(FRAME_LEN_2T - 1) : 3'(FRAME_LEN_1T - 1);
  endfunction

endpackage

// File: rtl/ad9361_tx_framer_if.sv
// Sample-set stream from the DSP side into the TX framer.
// A set transfers on a clock edge where s_valid and s_ready are both high;
// while s_valid=1 and s_ready=0 the source holds every s_* signal stable.
interface ad9361_tx_framer_if;
  import ad9361_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_i0;
  logic [SAMPLE_W-1:0] s_q0;
  logic [SAMPLE_W-1:0] s_i1;
  logic [SAMPLE_W-1:0] s_q1;

  modport master (
    output s_valid, s_i0, s_q0, s_i1, s_q1,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_i0, s_q0, s_i1, s_q1,
    output s_ready
  );

endinterface

// File: rtl/ad9361_tx_framer_word_mux.sv
// Selects the half-word and TX_FRAME level for a given phase of a 1T/2T frame.
// Purely combinational; the parent registers the result.
module ad9361_word_mux
  import ad9361_pkg::*;
(
  input  logic [2:0]        phase,
  input  iq_set_t           set,
  input  logic              mode_2t,
  output logic [WORD_W-1:0] data,
  output logic              frame
);

  logic [SAMPLE_W-1:0] comp;

  // phase[2:1] picks the component (I0,Q0,I1,Q1); phase[0] picks high/low half.
  always_comb begin
    comp = '0;
    unique case (phase[2:1])
      2'd0: comp = set.i0;
      2'd1: comp = set.q0;
      2'd2: comp = set.i1;
      2'd3: comp = set.q1;
      default: comp = '0;
    endcase
    data  = phase[0] ? comp[WORD_W-1:0] : comp[SAMPLE_W-1:WORD_W];
    frame = mode_2t ? ~phase[2] : ~phase[1];
  end

endmodule

// File: rtl/ad9361_tx_framer.sv
// AD9361 TX framer: serializes accepted I/Q sets into 6-bit half-words with
// TX_FRAME, one word per clk, with zero fill and counting on underrun.
module ad9361_tx_framer
  import ad9361_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 mode_2t,
  ad9361_tx_framer_if.slave    s,
  output logic [WORD_W-1:0]    tx_data,
  output logic                 tx_frame,
  output logic                 tx_active,
  output logic                 underrun,
  input  logic                 underrun_clr,
  output logic [CNT_W-1:0]     underrun_cnt,
  output state_t               state_dbg,
  output logic [2:0]           phase_dbg
);

  state_t            state;
  logic [2:0]        phase;
  iq_set_t           cur;
  logic              mode_q;

  logic              last_word;
  logic              frame_start;
  logic              underrun_evt;
  iq_set_t           in_set;
  iq_set_t           fill_set;
  logic [2:0]        mux_phase;
  iq_set_t           mux_set;
  logic              mux_mode;
  logic [WORD_W-1:0] mux_data;
  logic              mux_frame;

  assign last_word = (phase == last_phase(mode_q));
  assign s.s_ready = enable && ((state == IDLE) || last_word);

  // In RUN, the last word of a frame is the only point where a new frame may start.
  assign frame_start  = enable && ((state == IDLE) ? s.s_valid : last_word);
  assign underrun_evt = (state == RUN) && last_word && enable && !s.s_valid;

  always_comb begin
    in_set.i0 = s.s_i0;
    in_set.q0 = s.s_q0;
    in_set.i1 = s.s_i1;
    in_set.q1 = s.s_q1;
    fill_set  = s.s_valid ? in_set : '0;
  end

  // Look ahead one word so the mux output can be registered onto tx_data.
  always_comb begin
    mux_phase = phase + 3'd1;
    mux_set   = cur;
    mux_mode  = mode_q;
    if (frame_start) begin
      mux_phase = 3'd0;
      mux_set   = fill_set;
      mux_mode  = mode_2t;
    end
  end

  ad9361_word_mux u_word_mux (
    .phase   (mux_phase),
    .set     (mux_set),
    .mode_2t (mux_mode),
    .data    (mux_data),
    .frame   (mux_frame)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= 3'd0;
      cur       <= '0;
      mode_q    <= 1'b0;
      tx_data   <= '0;
      tx_frame  <= 1'b0;
      tx_active <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= RUN;
            cur       <= in_set;
            mode_q    <= mode_2t;
            phase     <= 3'd0;
            tx_data   <= mux_data;
            tx_frame  <= mux_frame;
            tx_active <= 1'b1;
          end
        end
        RUN: begin
          if (!last_word) begin
            phase    <= mux_phase;
            tx_data  <= mux_data;
            tx_frame <= mux_frame;
          end else if (enable) begin
            cur      <= fill_set;
            mode_q   <= mode_2t;
            phase    <= 3'd0;
            tx_data  <= mux_data;
            tx_frame <= mux_frame;
          end else begin
            state     <= IDLE;
            phase     <= 3'd0;
            tx_data   <= '0;
            tx_frame  <= 1'b0;
            tx_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new underrun outranks a coincident clear, so the count restarts at one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (underrun_evt) begin
      underrun <= 1'b1;
      if (underrun_clr) begin
        underrun_cnt <= CNT_W'(1);
      end else if (underrun_cnt != {CNT_W{1'b1}}) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
    end else if (underrun_clr) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end
  end

  assign state_dbg = state;
  assign phase_dbg = phase;

endmodule

// File: tb/tb_ad9361_tx_framer.sv
// Bench for ad9361_tx_framer: directed scenarios then random traffic, all
// checked every cycle against a word-queue model of the frame stream.
module tb_ad9361_tx_framer;
  import ad9361_pkg::*;

  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             mode_2t;
  logic             underrun_clr;
  logic [5:0]       tx_data;
  logic             tx_frame;
  logic             tx_active;
  logic             underrun;
  logic [CNT_W-1:0] underrun_cnt;
  state_t           state_dbg;
  logic [2:0]       phase_dbg;

  ad9361_tx_framer_if bus ();

  ad9361_tx_framer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .mode_2t      (mode_2t),
    .s            (bus),
    .tx_data      (tx_data),
    .tx_frame     (tx_frame),
    .tx_active    (tx_active),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt),
    .state_dbg    (state_dbg),
    .phase_dbg    (phase_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [5:0] d;
    logic       f;
  } word_t;

  word_t out_q[$];
  bit    running;
  bit    m_uflag;
  int    m_ucnt;
  bit    last_hs;
  int    n_pass = 0;
  int    n_fail = 0;
  int    n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return enable && (!running || out_q.size() == 1);
  endfunction

  // A frame is just its components cut into 6-bit halves, first half of them framed.
  function automatic void push_frame(input logic [11:0] c0, input logic [11:0] c1,
                                     input logic [11:0] c2, input logic [11:0] c3,
                                     input bit two);
    logic [11:0] comps[4];
    int n;
    word_t w;
    comps = '{c0, c1, c2, c3};
    n = two ? 4 : 2;
    for (int k = 0; k < n; k++) begin
      w.f = (k < n / 2);
      w.d = 6'(comps[k] / 64);
      out_q.push_back(w);
      w.d = 6'(comps[k] % 64);
      out_q.push_back(w);
    end
  endfunction

  task automatic model_update();
    bit und;
    bit hs;
    und = 1'b0;
    if (!reset_n) begin
      running = 1'b0;
      out_q.delete();
      m_uflag = 1'b0;
      m_ucnt  = 0;
      last_hs = 1'b0;
      return;
    end
    hs = exp_ready() && bus.s_valid;
    if (running) begin
      void'(out_q.pop_front());
      if (out_q.size() == 0) begin
        if (enable) begin
          if (bus.s_valid) push_frame(bus.s_i0, bus.s_q0, bus.s_i1, bus.s_q1, mode_2t);
          else begin
            push_frame(12'd0, 12'd0, 12'd0, 12'd0, mode_2t);
            und = 1'b1;
          end
        end else begin
          running = 1'b0;
        end
      end
    end else if (hs) begin
      push_frame(bus.s_i0, bus.s_q0, bus.s_i1, bus.s_q1, mode_2t);
      running = 1'b1;
    end
    if (und) begin
      m_uflag = 1'b1;
      m_ucnt  = underrun_clr ? 1 : ((m_ucnt < CNT_MAX) ? m_ucnt + 1 : CNT_MAX);
    end else if (underrun_clr) begin
      m_uflag = 1'b0;
      m_ucnt  = 0;
    end
    last_hs = hs;
  endtask

  task automatic check_outputs();
    word_t w;
    w = running ? out_q[0] : '0;
    chk("tx_data", tx_data, w.d);
    chk("tx_frame", tx_frame, w.f);
    chk("tx_active", tx_active, running);
    chk("underrun", underrun, m_uflag);
    chk("underrun_cnt", underrun_cnt, m_ucnt);
    chk("state_run", state_dbg == RUN, running);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    #1;
    chk("s_ready", bus.s_ready, exp_ready());
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_data();
    bus.s_i0 = 12'($urandom_range(0, 4095));
    bus.s_q0 = 12'($urandom_range(0, 4095));
    bus.s_i1 = 12'($urandom_range(0, 4095));
    bus.s_q1 = 12'($urandom_range(0, 4095));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    bus.s_valid = 1'b0;
    underrun_clr = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  logic [5:0] t1_words[4] = '{6'h2A, 6'h3C, 6'h04, 6'h23};
  logic [5:0] t2_words[8] = '{6'h20, 6'h00, 6'h1F, 6'h3F, 6'h00, 6'h01, 6'h3F, 6'h3F};

  // ---------------- directed + random sequence ----------------
  initial begin
    int budget;
    reset_n = 1'b0;
    enable = 1'b0;
    mode_2t = 1'b0;
    underrun_clr = 1'b0;
    bus.s_valid = 1'b0;
    rand_data();
    running = 1'b0;
    m_uflag = 1'b0;
    m_ucnt = 0;
    last_hs = 1'b0;
    @(negedge clk);
    do_reset();
    chk("reset_tx_data", tx_data, 6'd0);
    chk("reset_cnt", underrun_cnt, '0);

    // 1T continuous stream
    mode_2t = 1'b0; enable = 1'b1; bus.s_valid = 1'b1;
    rand_data(); bus.s_i0 = 12'hABC; bus.s_q0 = 12'h123;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t1_word", tx_data, t1_words[k % 4]);
      chk("t1_frame", tx_frame, (k % 4) < 2);
    end

    // 2T known pattern
    do_reset();
    mode_2t = 1'b1; enable = 1'b1; bus.s_valid = 1'b1;
    bus.s_i0 = 12'h800; bus.s_q0 = 12'h7FF; bus.s_i1 = 12'h001; bus.s_q1 = 12'hFFF;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t2_word", tx_data, t2_words[k]);
      chk("t2_frame", tx_frame, k < 4);
    end

    // three underrun frames in 1T, then clear
    do_reset();
    mode_2t = 1'b0; enable = 1'b1; bus.s_valid = 1'b1; rand_data();
    repeat (4) cycle();
    bus.s_valid = 1'b0;
    repeat (9) cycle();
    bus.s_valid = 1'b1; rand_data();
    repeat (3) cycle();
    chk("t3_flag", underrun, 1'b1);
    chk("t3_cnt", underrun_cnt, 3);
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    chk("t3_clr_flag", underrun, 1'b0);
    chk("t3_clr_cnt", underrun_cnt, 0);

    // counter saturation, then clear coincident with an underrun
    do_reset();
    mode_2t = 1'b0; enable = 1'b1; bus.s_valid = 1'b1; rand_data();
    cycle();
    bus.s_valid = 1'b0;
    budget = 200;
    while (m_ucnt < CNT_MAX - 1 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("t4_reach", budget > 0, 1'b1);
    chk("t4_cnt_max_m1", underrun_cnt, CNT_MAX - 1);
    repeat (12) cycle();
    chk("t4_sat", underrun_cnt, CNT_MAX);
    budget = 10;
    while (budget > 0) begin
      underrun_clr = running && (out_q.size() == 1) && enable && !bus.s_valid;
      cycle();
      budget--;
      if (underrun_clr) break;
    end
    underrun_clr = 1'b0;
    chk("t4_clr_wins", underrun_cnt, 1);
    chk("t4_clr_flag", underrun, 1'b1);

    // enable drop mid 2T frame, then reset mid frame
    do_reset();
    mode_2t = 1'b1; enable = 1'b1; bus.s_valid = 1'b1; rand_data();
    repeat (2) cycle();
    enable = 1'b0; bus.s_valid = 1'b0;
    repeat (6) cycle();
    chk("t5_last_active", tx_active, 1'b1);
    cycle();
    chk("t5_idle_active", tx_active, 1'b0);
    chk("t5_idle_data", tx_data, 6'd0);
    enable = 1'b1; bus.s_valid = 1'b1; rand_data();
    repeat (3) cycle();
    reset_n = 1'b0;
    cycle();
    chk("t5_rst_active", tx_active, 1'b0);
    chk("t5_rst_data", tx_data, 6'd0);
    chk("t5_rst_frame", tx_frame, 1'b0);
    reset_n = 1'b1;
    bus.s_valid = 1'b0;
    cycle();

    // mode change mid 1T frame applies to the next frame only
    do_reset();
    mode_2t = 1'b0; enable = 1'b1; bus.s_valid = 1'b1; rand_data();
    repeat (3) cycle();
    mode_2t = 1'b1;
    cycle();
    chk("t6_old_len_frame", tx_frame, 1'b0);
    chk("t6_old_len_active", tx_active, 1'b1);
    repeat (4) cycle();
    chk("t6_new_len_frame", tx_frame, 1'b1);

    // random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!bus.s_valid || last_hs) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        rand_data();
      end
      enable       = ($urandom_range(0, 15) != 0);
      mode_2t      = 1'($urandom_range(0, 1));
      underrun_clr = ($urandom_range(0, 19) == 0);
      reset_n      = ($urandom_range(0, 149) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
